gf_mult_seq: RTL and testbench
==============================

// Module: gf_mult_seq
// PURPOSE
//  Parametrised bit-serial GF(2^M) arithmetic unit for the RS/ECC encode path.
//  Op 0: multiply two field elements a*b mod POLY; op 1: reduce a (2M-1)-bit
//  polynomial product into the field. One operand bit per clock, LSB-first,
//  with a start/ready/done handshake. Replaces fixed-field table lookups.
// PARAMETERS
//  M     6             field width in bits (2..16)
//  POLY  7'b1000011    primitive polynomial, M+1 bits, POLY[M] must be 1 (x^6+x+1)
// PORTS
//  clk     in   1       single clock; all logic on posedge clk
//  reset   in   1       asynchronous, active-high reset
//  start   in   1       request; accepted only when ready=1
//  op      in   1       0 = multiply, 1 = reduce; sampled with start
//  a       in   M       multiplicand (op 0); ignored for op 1
//  b       in   2M-1    multiplier in b[M-1:0] (op 0, upper bits ignored); polynomial to reduce (op 1)
//  clear   in   1       synchronous abort, returns to IDLE
//  ready   out  1       high in IDLE
//  busy    out  1       high in RUN
//  done    out  1       one-cycle pulse, z valid
//  z       out  M       result, registered, held until next completion
// BEHAVIOUR
//  - Reset (async, active-high): state=IDLE, z=0, done=0, busy=0, ready=1, internal regs 0.
//  - Regs: apow[M-1:0], shreg[2M-2:0], acc[M-1:0], cnt (ceil(log2(2M)) bits).
//  - xtime(v) = v[M-1] ? ({v[M-2:0],1'b0} ^ POLY[M-1:0]) : {v[M-2:0],1'b0}.
//  - IDLE: start=1 -> load apow=(op?1:a), shreg=(op?b:{zeros,b[M-1:0]}), acc=0,
//    cnt=N (N=M for op 0, 2M-1 for op 1); go RUN. start while not IDLE ignored.
//  - RUN step: if shreg[0] acc^=apow; apow<=xtime(apow); shreg>>=1; cnt--.
//    Last step (cnt==1) -> z <= acc_next, go DONE. Exactly N RUN cycles.
//  - DONE: done=1 for one cycle, then IDLE. start during DONE ignored.
//  - Latency: start sampled at edge 0 -> done high after edge N -> ready after edge N+1.
//    Back-to-back throughput: one op per N+2 cycles.
//  - clear (synchronous) in any state -> IDLE next edge; no done, z unchanged.
//    clear has priority over start in the same cycle.
//  - reset asserted mid-op: immediate IDLE, z=0, no done pulse.
//  - Operand zero: a=0 or b=0 yields z=0 after full latency (no special case).
//  - All arithmetic is carry-less XOR; no value exceeds M bits after xtime.
// CONFIGURATION
//  GF_MULT_EARLY_EXIT_EN defined: RUN terminates on the step where shreg_next==0
//    (or cnt==1, whichever first); latency N' = max(1, index of highest set bit
//    of operand + 1). Result identical. shreg==0 at load -> 1 RUN cycle, z=0.
//  Not defined: fixed latency N regardless of operand value; early-exit logic absent.
// TESTING (M=6, POLY=7'b1000011 unless noted)
//  - op0 a=6'h02 b=6'h20 -> z=6'h03, done exactly 6 clocks after start edge.
//  - op0 a=6'h20 b=6'h20 -> z=6'h30; op1 b=11'h400 -> z=6'h30 after 11 clocks.
//  - op0 a=6'h00 b=6'h15 -> z=0; op0 a=6'h01 b=6'h3F -> z=6'h3F; start pulsed
//    during RUN/DONE ignored, result unchanged.
//  - clear asserted in 3rd RUN cycle -> no done, IDLE next edge, z keeps prior value;
//    async reset mid-RUN -> z=0, ready=1 without clock edge.
//  - EARLY_EXIT_EN: op0 a=6'h25 b=6'h01 -> z=6'h25, done 1 clock after start;
//    without macro same result after 6 clocks.
//  - Exhaustive op0 sweep 64x64 vs reference log/antilog model; repeat with M=8,
//    POLY=9'h11D, random 10k pairs, zero mismatches.

Source files
------------

// File: rtl/gf_mult_seq_if.sv
// Operand/result bundle for the bit-serial GF(2^M) unit.
// master drives start/op/a/b/clear and observes ready/busy/done/z;
// slave is the arithmetic unit side of the same wires.
// Ports: start, op, a[M-1:0], b[2M-2:0], clear -> unit; ready, busy, done, z[M-1:0] <- unit.
interface gf_mult_seq_if #(
    parameter int M = 6
);
    logic           start;
    logic           op;
    logic [M-1:0]   a;
    logic [2*M-2:0] b;
    logic           clear;
    logic           ready;
    logic           busy;
    logic           done;
    logic [M-1:0]   z;

    modport master (
        output start, op, a, b, clear,
        input  ready, busy, done, z
    );

    modport slave (
        input  start, op, a, b, clear,
        output ready, busy, done, z
    );
endinterface

// File: rtl/gf_mult_seq.sv
// Purpose: bit-serial GF(2^M) multiply (op 0) or reduce a (2M-1)-bit polynomial (op 1), LSB-first.
// Latency: N = M (op 0) or 2M-1 (op 1) cycles from start edge to done; one op every N+2 cycles.
// Backpressure: start only accepted while ready (IDLE); start in RUN/DONE is dropped, clear aborts.
//
// Ports: clk, reset (async, active-high), bus (gf_mult_seq_if.slave):
//   start/op/a/b  request and operands, sampled on the accepting edge
//   clear         synchronous abort back to IDLE, z untouched, no done
//   ready/busy    IDLE / RUN indicators; done is a one-cycle pulse with z valid
//   z             registered result, held until the next completion
// Optional build macro: GF_MULT_EARLY_EXIT_EN -- finish as soon as no set operand bits remain.
module gf_mult_seq #(
    parameter int         M    = 6,
    parameter logic [M:0] POLY = 7'b1000011
) (
    input  logic          clk,
    input  logic          reset,
    gf_mult_seq_if.slave  bus
);

    localparam int W  = 2 * M - 1;
    localparam int CW = $clog2(2 * M);

    localparam logic [CW-1:0] N_MUL   = CW'(M);
    localparam logic [CW-1:0] N_RED   = CW'(W);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [M-1:0]   apow, apow_nxt;
    logic [W-1:0]   shreg, shreg_nxt;
    logic [M-1:0]   acc, acc_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [M-1:0]   z_q, z_nxt;

    logic [M-1:0]   acc_step;
    logic [M-1:0]   apow_step;
    logic [W-1:0]   shreg_step;
    logic           last_step;

    // Multiply by x modulo POLY: shift left, fold the overflowing x^M term back in.
    function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
        logic [M-1:0] sh;
        sh = {v[M-2:0], 1'b0};
        return v[M-1] ? (sh ^ POLY[M-1:0]) : sh;
    endfunction

    // One serial step: apow holds a*x^i (or x^i when reducing) for the bit
    // currently at shreg[0], so a set bit folds that power into the sum.
    always_comb begin
        acc_step   = shreg[0] ? (acc ^ apow) : acc;
        apow_step  = xtime(apow);
        shreg_step = shreg >> 1;
`ifdef GF_MULT_EARLY_EXIT_EN
        // Once the remaining operand bits are all zero, further steps cannot change acc.
        last_step  = (cnt == CNT_ONE) || (shreg_step == '0);
`else
        last_step  = (cnt == CNT_ONE);
`endif
    end

    always_comb begin
        state_nxt = state;
        apow_nxt  = apow;
        shreg_nxt = shreg;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        z_nxt     = z_q;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.op) begin
                        // Reduction: sum x^i mod POLY over the set bits of b.
                        apow_nxt  = {{(M-1){1'b0}}, 1'b1};
                        shreg_nxt = bus.b;
                        cnt_nxt   = N_RED;
                    end else begin
                        apow_nxt  = bus.a;
                        shreg_nxt = {{(W-M){1'b0}}, bus.b[M-1:0]};
                        cnt_nxt   = N_MUL;
                    end
                    acc_nxt   = '0;
                    state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                acc_nxt   = acc_step;
                apow_nxt  = apow_step;
                shreg_nxt = shreg_step;
                cnt_nxt   = cnt - CNT_ONE;
                if (last_step) begin
                    z_nxt     = acc_step;
                    state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a start in the same cycle.
        if (bus.clear) begin
            state_nxt = S_IDLE;
            apow_nxt  = apow;
            shreg_nxt = shreg;
            acc_nxt   = acc;
            cnt_nxt   = cnt;
            z_nxt     = z_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            apow  <= '0;
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
            z_q   <= '0;
        end else begin
            state <= state_nxt;
            apow  <= apow_nxt;
            shreg <= shreg_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            z_q   <= z_nxt;
        end
    end

    // Status decoded straight from the state register, so done is a clean one-cycle pulse.
    assign bus.ready = (state == S_IDLE);
    assign bus.busy  = (state == S_RUN);
    assign bus.done  = (state == S_DONE);
    assign bus.z     = z_q;

endmodule

// File: tb/tb_gf_mult_seq.sv
// Directed and swept checks of gf_mult_seq at M=6, POLY=x^6+x+1.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Expected latency follows GF_MULT_EARLY_EXIT_EN when the bench is built with it.
module tb_gf_mult_seq;

    localparam int         M    = 6;
    localparam logic [M:0] POLY = 7'b1000011;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    gf_mult_seq_if #(.M(M)) bus ();

    gf_mult_seq #(.M(M), .POLY(POLY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: long-division reduction of a full carry-less product.
    function automatic logic [5:0] ref_reduce(input logic [10:0] p);
        logic [10:0] r;
        r = p;
        for (int i = 10; i >= 6; i--)
            if (r[i]) r = r ^ (11'(POLY) << (i - 6));
        return r[5:0];
    endfunction

    function automatic logic [5:0] ref_mul(input logic [5:0] x, input logic [5:0] y);
        logic [10:0] p;
        p = '0;
        for (int i = 0; i < 6; i++)
            if (y[i]) p = p ^ (11'(x) << i);
        return ref_reduce(p);
    endfunction

    function automatic int exp_lat(input logic op_i, input logic [10:0] b_i);
        int n;
        n = op_i ? 11 : 6;
`ifdef GF_MULT_EARLY_EXIT_EN
        begin
            int hb;
            hb = -1;
            for (int i = 0; i < n; i++)
                if (b_i[i]) hb = i;
            n = (hb + 1 < 1) ? 1 : hb + 1;
        end
`endif
        return n;
    endfunction

    // Issue one op, time it, check result, then check the done pulse ended and the unit is idle.
    task automatic run_op(input logic op_i, input logic [5:0] a_i, input logic [10:0] b_i,
                          input string tag, input logic [5:0] z_exp);
        int lat;
        bus.op    = op_i;
        bus.a     = a_i;
        bus.b     = b_i;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " done"}, 32'(bus.done), 32'd1);
        chk({tag, " z"}, 32'(bus.z), 32'(z_exp));
        chk({tag, " lat"}, lat, exp_lat(op_i, b_i));
        @(posedge clk); #1;
        chk({tag, " pulse"}, {bus.done, bus.ready, bus.busy}, 3'b010);
    endtask

    initial begin
        int   cyc;
        int   seen;
        logic [10:0] rb;

        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.clear = 1'b0;

        // Reset state
        #12;
        chk("rst ready", 32'(bus.ready), 32'd1);
        chk("rst busy",  32'(bus.busy),  32'd0);
        chk("rst done",  32'(bus.done),  32'd0);
        chk("rst z",     32'(bus.z),     32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Hand-computed vectors: x*x^5 = x^6 = x+1; x^5*x^5 = x^10 = x^5+x^4
        run_op(1'b0, 6'h02, 11'h020, "mul 02*20", 6'h03);
        run_op(1'b0, 6'h20, 11'h020, "mul 20*20", 6'h30);
        run_op(1'b1, 6'h00, 11'h400, "red 400",   6'h30);
        run_op(1'b1, 6'h00, 11'h041, "red 041",   6'h02);
        run_op(1'b0, 6'h00, 11'h015, "mul 00*15", 6'h00);
        run_op(1'b0, 6'h25, 11'h001, "mul 25*01", 6'h25);

        // start pulses during RUN and DONE are dropped
        bus.op = 1'b0; bus.a = 6'h01; bus.b = 11'h03F; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 40) begin
            if (cyc == 2) begin
                bus.start = 1'b1; bus.op = 1'b1; bus.a = 6'h00; bus.b = 11'h000;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("ign done", 32'(bus.done), 32'd1);
        chk("ign z", 32'(bus.z), 32'h3F);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 6'h00; bus.b = 11'h000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("ign after done", {bus.done, bus.ready, bus.busy}, 3'b010);
        chk("ign z held", 32'(bus.z), 32'h3F);
        @(posedge clk); #1;
        chk("ign still idle", {bus.done, bus.ready, bus.busy}, 3'b010);

        // clear in the 3rd RUN cycle
        bus.op = 1'b0; bus.a = 6'h02; bus.b = 11'h020; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("clr busy before", 32'(bus.busy), 32'd1);
        bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        chk("clr idle", {bus.done, bus.ready, bus.busy}, 3'b010);
        chk("clr z kept", 32'(bus.z), 32'h3F);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.done) seen++;
        end
        chk("clr no done", seen, 0);

        // clear beats start in the same cycle
        bus.clear = 1'b1; bus.start = 1'b1; bus.a = 6'h01; bus.b = 11'h001;
        @(posedge clk); #1;
        bus.clear = 1'b0; bus.start = 1'b0;
        chk("clr prio", {bus.done, bus.ready, bus.busy}, 3'b010);

        // async reset mid-RUN takes effect without a clock edge
        bus.op = 1'b0; bus.a = 6'h02; bus.b = 11'h020; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("arst busy before", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst ready", 32'(bus.ready), 32'd1);
        chk("arst busy",  32'(bus.busy),  32'd0);
        chk("arst done",  32'(bus.done),  32'd0);
        chk("arst z",     32'(bus.z),     32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(1'b0, 6'h02, 11'h020, "post rst 02*20", 6'h03);

        // Exhaustive multiply sweep against the reference
        for (int x = 0; x < 64; x++) begin
            for (int y = 0; y < 64; y++) begin
                run_op(1'b0, 6'(x), 11'(y), $sformatf("mul %0h*%0h", x, y),
                       ref_mul(6'(x), 6'(y)));
            end
        end

        // Random reductions
        for (int k = 0; k < 100; k++) begin
            rb = 11'($urandom_range(0, 2047));
            run_op(1'b1, 6'h00, rb, $sformatf("red %0h", rb), ref_reduce(rb));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
